// File: rtl/bp_update_queue.sv
// bp_update_queue: buffers up to two branch-retire updates per cycle from commit
// and drains them one per cycle, in program order, into the predictor update port.
// Optional feature macro: BP_UPD_STATS_EN adds saturating write/stall counters.
module bp_update_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ret0_valid_i,
  input  logic [63:0]              ret0_pc_i,
  input  logic                     ret0_taken_i,
  input  logic [63:0]              ret0_target_i,
  input  logic                     ret0_is_branch_i,
  input  logic                     ret0_is_indirect_i,
  input  logic                     ret1_valid_i,
  input  logic [63:0]              ret1_pc_i,
  input  logic                     ret1_taken_i,
  input  logic [63:0]              ret1_target_i,
  input  logic                     ret1_is_branch_i,
  input  logic                     ret1_is_indirect_i,
  output logic                     ret0_ready_o,
  output logic                     ret1_ready_o,
  input  logic                     stall_i,
  output logic                     update_valid_o,
  output logic [63:0]              pc_retire_o,
  output logic                     actual_taken_o,
  output logic [63:0]              actual_target_o,
  output logic                     is_branch_retire_o,
  output logic                     is_indirect_retire_o,
  output logic [$clog2(DEPTH):0]   count_o,
`ifdef BP_UPD_STATS_EN
  output logic [31:0]              stat_enq_o,
  output logic [31:0]              stat_stall_o,
`endif
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
    logic        is_branch;
    logic        is_indirect;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            acc0, acc1, keep0, keep1, fire;
  logic [1:0]      n_wr;
  logic [PW-1:0]   wr_idx1;
  entry_t          e0, e1, head;

  // Readiness looks only at registered occupancy, so stall_i never reaches it.
  always_comb begin
    ret0_ready_o = (count_q != CW'(DEPTH));
    ret1_ready_o = (count_q <= CW'(DEPTH - 2));
  end

  // Accept/filter retire slots and pick write slots; slot 0 is always older.
  always_comb begin
    acc0    = ret0_valid_i && ret0_ready_o;
    acc1    = ret1_valid_i && ret1_ready_o;
    keep0   = acc0 && (ret0_is_branch_i || ret0_is_indirect_i);
    keep1   = acc1 && (ret1_is_branch_i || ret1_is_indirect_i);
    n_wr    = {1'b0, keep0} + {1'b0, keep1};
    wr_idx1 = keep0 ? wr_ptr_q + PW'(1) : wr_ptr_q;
    e0      = '{pc: ret0_pc_i, taken: ret0_taken_i, target: ret0_target_i,
                is_branch: ret0_is_branch_i, is_indirect: ret0_is_indirect_i};
    e1      = '{pc: ret1_pc_i, taken: ret1_taken_i, target: ret1_target_i,
                is_branch: ret1_is_branch_i, is_indirect: ret1_is_indirect_i};
    fire    = (count_q != '0) && !stall_i;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    if (keep0) mem_d[wr_ptr_q] = e0;
    if (keep1) mem_d[wr_idx1]  = e1;
    wr_ptr_d = wr_ptr_q + PW'(n_wr);
    rd_ptr_d = rd_ptr_q + PW'(fire);
    count_d  = count_q + CW'(n_wr) - CW'(fire);
  end

  // State registers; async reset discards all entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head payload and status; payload forced to zero while empty.
  always_comb begin
    head                 = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    update_valid_o       = fire;
    pc_retire_o          = head.pc;
    actual_taken_o       = head.taken;
    actual_target_o      = head.target;
    is_branch_retire_o   = head.is_branch;
    is_indirect_retire_o = head.is_indirect;
    count_o              = count_q;
    full_o               = (count_q == CW'(DEPTH));
    empty_o              = (count_q == '0);
  end

`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_enq_q, stat_enq_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [32:0] enq_sum;

  // Saturating counters: entries written, and non-empty cycles held by stall.
  always_comb begin
    enq_sum      = {1'b0, stat_enq_q} + 33'(n_wr);
    stat_enq_d   = enq_sum[32] ? '1 : enq_sum[31:0];
    stat_stall_d = stat_stall_q;
    if ((count_q != '0) && stall_i && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_enq_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_enq_q   <= stat_enq_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  // Expose counters.
  always_comb begin
    stat_enq_o   = stat_enq_q;
    stat_stall_o = stat_stall_q;
  end
`endif

endmodule
